// File: rtl/cache_stat_counters.sv
// rtl/cache_stat_counters.sv - cache event counters with frozen snapshot and print pulse
module cache_stat_counters #(
  parameter int WIDTH      = 32,
  parameter int PRINT_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_valid,
  input  logic [1:0]       ev_type,
  input  logic             ev_hit,
  input  logic             clear,
  input  logic             print_req,
  output logic [WIDTH-1:0] ins_reads,
  output logic [WIDTH-1:0] ins_hit,
  output logic [WIDTH-1:0] ins_miss,
  output logic [WIDTH-1:0] data_reads,
  output logic [WIDTH-1:0] data_writes,
  output logic [WIDTH-1:0] data_hit,
  output logic [WIDTH-1:0] data_miss,
  output logic             print,
  output logic             busy,
  output logic             bad_event
);

  localparam int HW = (PRINT_HOLD > 1) ? $clog2(PRINT_HOLD) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(PRINT_HOLD - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_PRINT,
    ST_RECOVER
  } state_t;

  state_t          state;
  logic            pending;
  logic [HW-1:0]   hold_cnt;

  logic [WIDTH-1:0] live_ins_reads;
  logic [WIDTH-1:0] live_ins_hit;
  logic [WIDTH-1:0] live_ins_miss;
  logic [WIDTH-1:0] live_data_reads;
  logic [WIDTH-1:0] live_data_writes;
  logic [WIDTH-1:0] live_data_hit;
  logic [WIDTH-1:0] live_data_miss;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + WIDTH'(1);
  endfunction

  // Live event counting; clear discards any same-cycle event, bad_event survives clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_ins_reads   <= '0;
      live_ins_hit     <= '0;
      live_ins_miss    <= '0;
      live_data_reads  <= '0;
      live_data_writes <= '0;
      live_data_hit    <= '0;
      live_data_miss   <= '0;
      bad_event        <= 1'b0;
    end else if (clear) begin
      live_ins_reads   <= '0;
      live_ins_hit     <= '0;
      live_ins_miss    <= '0;
      live_data_reads  <= '0;
      live_data_writes <= '0;
      live_data_hit    <= '0;
      live_data_miss   <= '0;
    end else if (ev_valid) begin
      case (ev_type)
        2'd0: begin
          live_data_reads <= sat_inc(live_data_reads);
          if (ev_hit) live_data_hit  <= sat_inc(live_data_hit);
          else        live_data_miss <= sat_inc(live_data_miss);
        end
        2'd1: begin
          live_data_writes <= sat_inc(live_data_writes);
          if (ev_hit) live_data_hit  <= sat_inc(live_data_hit);
          else        live_data_miss <= sat_inc(live_data_miss);
        end
        2'd2: begin
          live_ins_reads <= sat_inc(live_ins_reads);
          if (ev_hit) live_ins_hit  <= sat_inc(live_ins_hit);
          else        live_ins_miss <= sat_inc(live_ins_miss);
        end
        default: bad_event <= 1'b1;
      endcase
    end
  end

  // Snapshot/print sequencer; requests arriving while busy merge into one pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pending     <= 1'b0;
      hold_cnt    <= '0;
      print       <= 1'b0;
      busy        <= 1'b0;
      ins_reads   <= '0;
      ins_hit     <= '0;
      ins_miss    <= '0;
      data_reads  <= '0;
      data_writes <= '0;
      data_hit    <= '0;
      data_miss   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (print_req) begin
            state <= ST_SNAP;
            busy  <= 1'b1;
          end
        end
        ST_SNAP: begin
          ins_reads   <= live_ins_reads;
          ins_hit     <= live_ins_hit;
          ins_miss    <= live_ins_miss;
          data_reads  <= live_data_reads;
          data_writes <= live_data_writes;
          data_hit    <= live_data_hit;
          data_miss   <= live_data_miss;
          hold_cnt    <= '0;
          print       <= 1'b1;
          state       <= ST_PRINT;
          if (print_req) pending <= 1'b1;
        end
        ST_PRINT: begin
          if (print_req) pending <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            print <= 1'b0;
            state <= ST_RECOVER;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RECOVER: begin
          if (pending || print_req) begin
            pending <= 1'b0;
            state   <= ST_SNAP;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          print <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_stat_counters.sv
// tb/tb_cache_stat_counters.sv - self-checking bench for cache_stat_counters
module tb_cache_stat_counters;

  localparam int PH = 2;

  logic       clk;
  logic       rst_n;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic       ev_hit;
  logic       clear;
  logic       print_req;

  // count index: 0 data_reads, 1 data_writes, 2 data_hit, 3 data_miss, 4 ins_reads, 5 ins_hit, 6 ins_miss
  logic [31:0] a_cnt [7];
  logic [3:0]  b_cnt [7];
  logic a_print, a_busy, a_bad;
  logic b_print, b_busy, b_bad;

  int tests = 0;
  int fails = 0;

  cache_stat_counters #(.WIDTH(32), .PRINT_HOLD(PH)) u_w32 (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_type(ev_type), .ev_hit(ev_hit),
    .clear(clear), .print_req(print_req),
    .ins_reads(a_cnt[4]), .ins_hit(a_cnt[5]), .ins_miss(a_cnt[6]),
    .data_reads(a_cnt[0]), .data_writes(a_cnt[1]), .data_hit(a_cnt[2]), .data_miss(a_cnt[3]),
    .print(a_print), .busy(a_busy), .bad_event(a_bad)
  );

  cache_stat_counters #(.WIDTH(4), .PRINT_HOLD(PH)) u_w4 (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_type(ev_type), .ev_hit(ev_hit),
    .clear(clear), .print_req(print_req),
    .ins_reads(b_cnt[4]), .ins_hit(b_cnt[5]), .ins_miss(b_cnt[6]),
    .data_reads(b_cnt[0]), .data_writes(b_cnt[1]), .data_hit(b_cnt[2]), .data_miss(b_cnt[3]),
    .print(b_print), .busy(b_busy), .bad_event(b_bad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the design at each rising edge.
  logic       s_rstn, s_valid, s_hit, s_clear, s_req;
  logic [1:0] s_type;
  always @(posedge clk) begin
    s_rstn  <= rst_n;
    s_valid <= ev_valid;
    s_type  <= ev_type;
    s_hit   <= ev_hit;
    s_clear <= clear;
    s_req   <= print_req;
  end

  // Behavioural model: counts as saturating integers, print timing as edge offsets from the accepted request.
  longint live [2][7];
  longint snap [2][7];
  longint mx   [2];
  bit     m_bad, m_active, m_pend;
  int     m_rel;
  string  cname [7];

  initial begin
    mx[0] = 64'hFFFF_FFFF;
    mx[1] = 15;
    cname = '{"data_reads", "data_writes", "data_hit", "data_miss", "ins_reads", "ins_hit", "ins_miss"};
    forever begin
      @(negedge clk);
      if (!s_rstn || !rst_n) begin
        for (int w = 0; w < 2; w++)
          for (int i = 0; i < 7; i++) begin
            live[w][i] = 0;
            snap[w][i] = 0;
          end
        m_bad = 0; m_active = 0; m_pend = 0; m_rel = 0;
      end else begin
        if (m_active) begin
          m_rel++;
          if (m_rel == 1)
            for (int w = 0; w < 2; w++)
              for (int i = 0; i < 7; i++) snap[w][i] = live[w][i];
          if (m_rel == PH + 2) begin
            if (m_pend || s_req) begin
              m_rel = 0;
              m_pend = 0;
            end else begin
              m_active = 0;
            end
          end else if (s_req) begin
            m_pend = 1;
          end
        end else if (s_req) begin
          m_active = 1;
          m_rel = 0;
        end
        if (s_clear) begin
          for (int w = 0; w < 2; w++)
            for (int i = 0; i < 7; i++) live[w][i] = 0;
        end else if (s_valid) begin
          if (s_type == 2'd3) begin
            m_bad = 1;
          end else begin
            for (int w = 0; w < 2; w++) begin
              int tot, hi, mi;
              tot = (s_type == 2'd0) ? 0 : (s_type == 2'd1) ? 1 : 4;
              hi  = (s_type == 2'd2) ? 5 : 2;
              mi  = (s_type == 2'd2) ? 6 : 3;
              if (live[w][tot] < mx[w]) live[w][tot]++;
              if (s_hit) begin
                if (live[w][hi] < mx[w]) live[w][hi]++;
              end else begin
                if (live[w][mi] < mx[w]) live[w][mi]++;
              end
            end
          end
        end
      end
      for (int i = 0; i < 7; i++) begin
        check({"w32 ", cname[i]}, longint'(a_cnt[i]), snap[0][i]);
        check({"w4 ", cname[i]}, longint'(b_cnt[i]), snap[1][i]);
      end
      check("w32 print", longint'(a_print), longint'(m_active && m_rel >= 1 && m_rel <= PH));
      check("w4 print", longint'(b_print), longint'(m_active && m_rel >= 1 && m_rel <= PH));
      check("w32 busy", longint'(a_busy), longint'(m_active));
      check("w4 busy", longint'(b_busy), longint'(m_active));
      check("w32 bad_event", longint'(a_bad), longint'(m_bad));
      check("w4 bad_event", longint'(b_bad), longint'(m_bad));
    end
  end

  task automatic drive(input logic v, input logic [1:0] t, input logic h, input logic c, input logic r);
    ev_valid = v; ev_type = t; ev_hit = h; clear = c; print_req = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [11:0] pat;
  int          npr, first;

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst_n = 1'b0;
    ev_valid = 1'b0; ev_type = 2'd0; ev_hit = 1'b0; clear = 1'b0; print_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset data_reads", longint'(a_cnt[0]), 0);
    check("reset print", longint'(a_print), 0);
    check("reset busy", longint'(a_busy), 0);
    check("reset bad_event", longint'(a_bad), 0);
    rst_n = 1'b1;
    idle(2);

    // basic mix and print pulse shape
    repeat (3) drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("snap cycle print low", longint'(a_print), 0);
    check("snap cycle busy", longint'(a_busy), 1);
    npr = 0; first = -1;
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      if (a_print) begin
        npr++;
        if (first < 0) first = i;
      end
    end
    check("print high cycles", npr, 2);
    check("print rise offset", first, 1);
    check("t1 data_reads", longint'(a_cnt[0]), 5);
    check("t1 data_writes", longint'(a_cnt[1]), 1);
    check("t1 data_hit", longint'(a_cnt[2]), 3);
    check("t1 data_miss", longint'(a_cnt[3]), 3);
    check("t1 ins_reads", longint'(a_cnt[4]), 4);
    check("t1 ins_hit", longint'(a_cnt[5]), 4);
    check("t1 ins_miss", longint'(a_cnt[6]), 0);

    // events keep flowing while the snapshot is held
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    check("t2 print first", longint'(a_print), 1);
    check("t2 held data_reads", longint'(a_cnt[0]), 6);
    drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    check("t2 held data_reads late", longint'(a_cnt[0]), 6);
    check("t2 held data_hit late", longint'(a_cnt[2]), 4);
    repeat (5) drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("t2 second data_reads", longint'(a_cnt[0]), 13);
    check("t2 second data_hit", longint'(a_cnt[2]), 11);
    check("t2 second data_miss", longint'(a_cnt[3]), 3);

    // repeated requests while busy merge into one extra pulse
    for (int j = 0; j < 12; j++) begin
      drive(1'b0, 2'd0, 1'b0, 1'b0, (j <= 3) ? 1'b1 : 1'b0);
      pat[j] = a_print;
    end
    check("t3 print pattern", longint'(pat), 12'h066);

    // clear beats a simultaneous event
    drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(5);
    for (int i = 0; i < 7; i++) check("t4 cleared count", longint'(a_cnt[i]), 0);
    check("t4 w4 data_reads", longint'(b_cnt[0]), 0);

    // saturation of the narrow build
    repeat (20) drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("t5 w4 data_reads", longint'(b_cnt[0]), 15);
    check("t5 w4 data_hit", longint'(b_cnt[2]), 15);
    check("t5 w4 data_miss", longint'(b_cnt[3]), 0);
    check("t5 w32 data_reads", longint'(a_cnt[0]), 20);

    // reserved event type, sticky flag, async reset during print
    drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("t6 bad_event set", longint'(a_bad), 1);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("t6 data_reads unchanged", longint'(a_cnt[0]), 20);
    check("t6 data_hit unchanged", longint'(a_cnt[2]), 20);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("t6 bad_event after clear", longint'(a_bad), 1);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("t6 print before reset", longint'(a_print), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 print async drop", longint'(a_print), 0);
    check("t6 busy async drop", longint'(a_busy), 0);
    check("t6 bad_event reset", longint'(a_bad), 0);
    check("t6 data_reads reset", longint'(a_cnt[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("t6 idle after reset", longint'(a_busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_stat_counters.md
# cache_stat_counters

Event-counting stage directly upstream of the statistics printer. Counts data reads, data writes, instruction fetches and their hit/miss outcomes reported by the cache controller, one event per cycle. On request it freezes a snapshot of all counts onto its outputs and raises a `print` pulse, so the printer sees stable values on its rising `print` edge. Live counting continues while a snapshot is held.

## Interface
Parameters:
- `WIDTH`, 32: width of every counter and output count.
- `PRINT_HOLD`, 2: cycles `print` stays high per request (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ev_valid`  in  1  event strobe; one event per cycle when high.
- `ev_type`  in  2  0 = data read, 1 = data write, 2 = instruction fetch, 3 = reserved.
- `ev_hit`  in  1  1 = hit, 0 = miss; qualified by `ev_valid`.
- `clear`  in  1  synchronous zeroing of live counters.
- `print_req`  in  1  request a snapshot + print pulse (level sampled each cycle).
- `ins_reads`, `ins_hit`, `ins_miss`  out  WIDTH  snapshot instruction counts.
- `data_reads`, `data_writes`, `data_hit`, `data_miss`  out  WIDTH  snapshot data counts.
- `print`  out  1  high while snapshot is valid for the printer.
- `busy`  out  1  high in any state other than IDLE.
- `bad_event`  out  1  sticky; set by an `ev_type`=3 event.

## Operation
- Seven live counters, internal. On valid event:
  - type 0: `data_reads`+1; `data_hit`+1 if hit, else `data_miss`+1.
  - type 1: `data_writes`+1; `data_hit`/`data_miss` as above.
  - type 2: `ins_reads`+1; `ins_hit`/`ins_miss` as above.
  - type 3: no counter changes; `bad_event` set until reset (not cleared by `clear`).
- Counters saturate at all-ones; never wrap.
- `clear` zeroes all live counters; an event in the same cycle is discarded (clear wins). Snapshot outputs are not affected by `clear`.
- FSM states: IDLE, SNAP, PRINT, RECOVER.
  - IDLE: `print_req` → SNAP.
  - SNAP (1 cycle): load snapshot registers from live counters → PRINT.
  - PRINT: `print`=1 for exactly PRINT_HOLD cycles → RECOVER.
  - RECOVER (1 cycle, `print`=0): pending set → SNAP (pending cleared), else IDLE.
- `print_req` seen in SNAP/PRINT/RECOVER sets a single-bit pending flag; multiple requests merge into one.
- Snapshot includes every event sampled at or before the edge that enters SNAP→PRINT's load edge, i.e. all events accepted through the SNAP cycle's closing edge-1; events during SNAP cycle itself are excluded.
- `print_req` and `clear` in the same IDLE cycle: snapshot captures pre-clear values? No—clear applies first edge; snapshot loaded next edge shows zeros plus later events. Decided: snapshot reflects post-clear state.

## Timing
- Reset (async assert, sync-released use only): all live counters, snapshot outputs = 0; `print`=0; `busy`=0; `bad_event`=0; state IDLE; pending=0.
- Event accepted at edge N → live count updated after edge N.
- `print_req` sampled at edge N (IDLE) → SNAP after N; snapshot outputs loaded at edge N+1, includes events sampled through edge N; `print` high after edge N+1 through edge N+1+PRINT_HOLD; low ≥1 cycle (RECOVER) before any next rise. Minimum request-to-request period PRINT_HOLD+2 cycles.
- Snapshot outputs change only on the SNAP load edge; stable throughout `print` high.
- `busy` high from edge N to end of RECOVER.
- Reset asserted mid-PRINT: `print` drops immediately (async), pending lost.

## Test plan
- Reset, then 3 data-read hits, 2 data-read misses, 1 write miss, 4 fetch hits, `print_req` → outputs data_reads=5, data_writes=1, data_hit=3, data_miss=3, ins_reads=4, ins_hit=4, ins_miss=0; `print` high exactly 2 cycles, rising one cycle after SNAP.
- Events continuing every cycle during PRINT → snapshot outputs unchanged while `print`=1; second request shows accumulated totals.
- Three `print_req` pulses during PRINT → exactly one extra print pulse, separated by one low cycle.
- `clear` with simultaneous valid event, then print → all counts 0.
- Preload near saturation (WIDTH=4 build, 20 read hits) → data_reads=15, data_hit=15, no wrap.
- `ev_type`=3 event → no count change, `bad_event`=1, survives `clear`, cleared only by `rst_n`=0; `rst_n` asserted while `print`=1 → `print`=0 same cycle.
